// File: rtl/mpu_trap_unit_pkg.sv
// Shared MPU types: privilege levels, access kinds, trap cause codes and the
// fault record carried from the MPU fault detector to the core trap logic.
package mpu_trap_unit_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    MPU_ACC_EXEC  = 2'd0,
    MPU_ACC_LOAD  = 2'd1,
    MPU_ACC_STORE = 2'd2
  } mpu_acc_e;

  localparam logic [3:0] CAUSE_NONE         = 4'd0;
  localparam logic [3:0] CAUSE_INSTR_ACCESS = 4'd1;
  localparam logic [3:0] CAUSE_LOAD_ACCESS  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_ACCESS = 4'd7;

  typedef struct packed {
    logic [3:0]  cause;
    logic [31:0] tval;
    priv_e       priv;
  } fault_rec_t;

  localparam int unsigned FAULT_REC_W = $bits(fault_rec_t);

  // Fixed priority exec > load > store; lower faults in the same cycle vanish.
  function automatic logic [3:0] fault_cause(input logic f_exec, input logic f_load,
                                             input logic f_store);
    logic [3:0] c;
    if (f_exec) begin
      c = CAUSE_INSTR_ACCESS;
    end else if (f_load) begin
      c = CAUSE_LOAD_ACCESS;
    end else if (f_store) begin
      c = CAUSE_STORE_ACCESS;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/mpu_trap_unit_fault_fifo.sv
// Fault record queue: register-array FIFO with a zeroed head while empty, so the
// trap outputs read as all-zero (PRIV_U) whenever no record is pending.
module fault_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  always_comb begin
    valid     = (cnt_q != '0);
    full      = (cnt_q == CNT_FULL);
    do_pop_s  = valid && ready;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (valid) begin
      rdata = mem_q[rd_ptr_q];
    end else begin
      rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mpu_trap_unit.sv
// MPU trap unit: priority-encodes MPU faults into records, queues them for the
// core, and keeps a sticky overflow flag with a saturating dropped-record count.
module mpu_trap_unit
  import mpu_trap_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  priv_e            cur_priv,
  input  logic             fault_exec,
  input  logic             fault_load,
  input  logic             fault_store,
  output logic             trap_valid,
  input  logic             trap_ready,
  output logic [3:0]       trap_cause,
  output logic [31:0]      trap_tval,
  output priv_e            trap_priv,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_overflow
);

  fault_rec_t             rec_s, head_s;
  logic                   push_s, full_s, drop_s;
  logic [FAULT_REC_W-1:0] rdata_s;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

  always_comb begin
    push_s      = fault_exec || fault_load || fault_store;
    rec_s.cause = fault_cause(fault_exec, fault_load, fault_store);
    rec_s.tval  = addr;
    rec_s.priv  = cur_priv;
    drop_s      = push_s && full_s && !(trap_valid && trap_ready);
  end

  fault_fifo #(
    .WIDTH (FAULT_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (rec_s),
    .full  (full_s),
    .valid (trap_valid),
    .ready (trap_ready),
    .rdata (rdata_s)
  );

  assign head_s     = fault_rec_t'(rdata_s);
  assign trap_cause = head_s.cause;
  assign trap_tval  = head_s.tval;
  assign trap_priv  = head_s.priv;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mpu_trap_unit.sv
// Scoreboard bench for mpu_trap_unit: expected records are queued as faults are
// driven and compared against the trap head whenever the core pops it.
module tb_mpu_trap_unit;
  import mpu_trap_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      addr;
  priv_e            cur_priv;
  logic             fe, fl, fs;
  logic             trap_valid, trap_ready;
  logic [3:0]       trap_cause;
  logic [31:0]      trap_tval;
  priv_e            trap_priv;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr_overflow;

  mpu_trap_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .cur_priv     (cur_priv),
    .fault_exec   (fe),
    .fault_load   (fl),
    .fault_store  (fs),
    .trap_valid   (trap_valid),
    .trap_ready   (trap_ready),
    .trap_cause   (trap_cause),
    .trap_tval    (trap_tval),
    .trap_priv    (trap_priv),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cause;
    logic [31:0] tval;
    priv_e       priv;
  } rec_t;

  rec_t             sb[$];
  logic             m_ovf;
  logic [CNT_W-1:0] m_drop;
  logic             m_pop, popped;
  rec_t             pop_obs, pop_exp;
  int               n_cmp = 0;
  int               n_err = 0;

  function automatic logic [3:0] exp_cause(input logic e, input logic l, input logic s);
    if (e) return 4'd1;
    if (l) return 4'd5;
    if (s) return 4'd7;
    return 4'd0;
  endfunction

  function automatic rec_t dut_head();
    rec_t r;
    r.cause = trap_cause;
    r.tval  = trap_tval;
    r.priv  = trap_priv;
    return r;
  endfunction

  // Drives one cycle of stimulus and advances the reference model across the edge.
  task automatic step(input logic e, input logic l, input logic s, input logic [31:0] a,
                      input priv_e p, input logic rdy, input logic clr);
    logic is_full, any, drop;
    rec_t nr;
    fe = e; fl = l; fs = s; addr = a; cur_priv = p; trap_ready = rdy; clr_overflow = clr;
    @(negedge clk);
    any     = e | l | s;
    is_full = (sb.size() == DEPTH);
    m_pop   = rdy && (sb.size() != 0);
    drop    = any && is_full && !m_pop;
    popped  = trap_valid && trap_ready;
    pop_obs = dut_head();
    if (m_pop) pop_exp = sb.pop_front();
    if (any && !drop) begin
      nr.cause = exp_cause(e, l, s);
      nr.tval  = a;
      nr.priv  = p;
      sb.push_back(nr);
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? CNT_W'(1) : ((m_drop == {CNT_W{1'b1}}) ? m_drop : m_drop + CNT_W'(1));
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    @(posedge clk);
    #1;
    fe = 1'b0; fl = 1'b0; fs = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; fe = 1'b0; fl = 1'b0; fs = 1'b0; trap_ready = 1'b0; clr_overflow = 1'b0;
    addr = 32'h0; cur_priv = PRIV_U;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_ovf = 1'b0; m_drop = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fe = 1'b1; fl = 1'b0; fs = 1'b0; addr = 32'hDEAD_BEEF; cur_priv = PRIV_M;
    trap_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", trap_valid); end
    n_cmp++; if (trap_cause !== 4'd0) begin n_err++; $display("FAIL reset_cause: got %h want 0", trap_cause); end
    n_cmp++; if (trap_tval !== 32'h0) begin n_err++; $display("FAIL reset_tval: got %h want 0", trap_tval); end
    n_cmp++; if (trap_priv !== PRIV_U) begin n_err++; $display("FAIL reset_priv: got %0d want 0", trap_priv); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst = 1'b0; fe = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_drop = '0;
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b0, 1'b0);
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL reset_fault_ignored: got %b want 0", trap_valid); end
  endtask

  task automatic test_single_exec();
    rec_t exp;
    exp.cause = 4'd1; exp.tval = 32'h8000_0000; exp.priv = PRIV_S;
    step(1'b1, 1'b0, 1'b0, 32'h8000_0000, PRIV_S, 1'b0, 1'b0);
    n_cmp++; if (trap_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", trap_valid); end
    n_cmp++; if (dut_head() !== exp) begin n_err++; $display("FAIL single_head: got %h want %h", dut_head(), exp); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b0, 1'b0);
      n_cmp++;
      if (trap_valid !== 1'b1 || dut_head() !== sb[0]) begin
        n_err++; $display("FAIL single_stable[%0d]: got v=%b %h want v=1 %h", i, trap_valid, dut_head(), sb[0]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL single_pop: got p=%b %h want %h", popped, pop_obs, pop_exp); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", trap_valid); end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b1, 1'b1, 32'h1000, PRIV_M, 1'b0, 1'b0);
    n_cmp++; if (trap_valid !== 1'b1 || trap_cause !== 4'd1) begin n_err++; $display("FAIL prio_all: got v=%b c=%0d want v=1 c=1", trap_valid, trap_cause); end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL prio_pop: got %h want %h", pop_obs, pop_exp); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL prio_occupancy: got v=%b want 0 (single record)", trap_valid); end
    step(1'b0, 1'b1, 1'b1, 32'h2000, PRIV_U, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL prio_load_store: got %h want %h", pop_obs, pop_exp); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL prio_ls_empty: got %b want 0", trap_valid); end
  endtask

  task automatic test_order();
    int pops = 0;
    step(1'b0, 1'b1, 1'b0, 32'h10, PRIV_U, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h20, PRIV_S, 1'b1, 1'b0);
    if (m_pop) begin pops++; n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL order_pop%0d: got %h want %h", pops, pop_obs, pop_exp); end end
    step(1'b1, 1'b0, 1'b0, 32'h30, PRIV_M, 1'b1, 1'b0);
    if (m_pop) begin pops++; n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL order_pop%0d: got %h want %h", pops, pop_obs, pop_exp); end end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
      if (m_pop) begin pops++; n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL order_pop%0d: got %h want %h", pops, pop_obs, pop_exp); end end
    end
    n_cmp++; if (pops != 3) begin n_err++; $display("FAIL order_count: got %0d want 3", pops); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL order_empty: got %b want 0", trap_valid); end
  endtask

  task automatic test_ready_no_valid();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (trap_valid !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL ready_idle: got v=%b o=%b want 0/0", trap_valid, overflow); end
    step(1'b0, 1'b0, 1'b1, 32'h44, PRIV_S, 1'b1, 1'b0);
    n_cmp++; if (trap_valid !== 1'b1 || dut_head() !== sb[0]) begin n_err++; $display("FAIL ready_first: got v=%b %h want v=1 %h", trap_valid, dut_head(), sb[0]); end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL ready_pop: got %h want %h", pop_obs, pop_exp); end
  endtask

  task automatic test_overflow();
    int pops = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), PRIV_U, 1'b0, 1'b0);
    n_cmp++; if (overflow !== m_ovf || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== m_drop || drop_cnt !== 8'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL ovf_clr: got %b/%0d want 0/0", overflow, drop_cnt); end
    n_cmp++; if (trap_valid !== 1'b1 || dut_head() !== sb[0]) begin n_err++; $display("FAIL ovf_intact: got %h want %h", dut_head(), sb[0]); end
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
      if (m_pop) begin pops++; n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL ovf_pop%0d: got %h want %h", pops, pop_obs, pop_exp); end end
    end
    n_cmp++; if (pops != DEPTH || trap_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %0d pops v=%b want %0d v=0", pops, trap_valid, DEPTH); end
  endtask

  task automatic test_full_pushpop();
    int pops = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i), PRIV_S, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h999, PRIV_M, 1'b1, 1'b0);
    n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL full_pp_pop: got %h want %h", pop_obs, pop_exp); end
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL full_pp_ovf: got %b/%0d want 0/0", overflow, drop_cnt); end
    trap_ready = 1'b0;
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
      if (m_pop) begin pops++; n_cmp++; if (!popped || pop_obs !== pop_exp) begin n_err++; $display("FAIL full_pp_drain%0d: got %h want %h", pops, pop_obs, pop_exp); end end
    end
    n_cmp++; if (pops != DEPTH || pop_obs.tval !== 32'h999) begin n_err++; $display("FAIL full_pp_last: got %0d pops tval=%h want %0d tval=999", pops, pop_obs.tval, DEPTH); end
  endtask

  task automatic test_clr_drop_saturate();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'h300 + 32'(i), PRIV_U, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h3FF, PRIV_U, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h400, PRIV_S, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1 || drop_cnt !== m_drop) begin n_err++; $display("FAIL clr_vs_drop: got %b/%0d want 1/1", overflow, drop_cnt); end
    for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 1'b1, 32'h500, PRIV_U, 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'hFF || drop_cnt !== m_drop) begin n_err++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL sat_clr: got %b/%0d want 0/0", overflow, drop_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h600, PRIV_S, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h604, PRIV_M, 1'b0, 1'b0);
    n_cmp++; if (trap_valid !== 1'b1 || dut_head() !== sb[0]) begin n_err++; $display("FAIL rmid_pre: got %h want %h", dut_head(), sb[0]); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_drop = '0;
    n_cmp++;
    if (trap_valid !== 1'b0 || trap_cause !== 4'd0 || trap_tval !== 32'h0 || trap_priv !== PRIV_U ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL rmid_outputs: got v=%b c=%h t=%h p=%0d o=%b d=%0d want all zero",
                        trap_valid, trap_cause, trap_tval, trap_priv, overflow, drop_cnt);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, PRIV_U, 1'b1, 1'b0);
    n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL rmid_discarded: got %b want 0", trap_valid); end
  endtask

  initial begin
    m_ovf = 1'b0; m_drop = '0; m_pop = 1'b0; popped = 1'b0;
    test_reset();
    test_single_exec();
    test_priority();
    test_order();
    test_ready_no_valid();
    test_overflow();
    test_full_pushpop();
    test_clr_drop_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
